// File: rtl/sram_arb_ctrl_pkg.sv
// Shared types for the two-requester SRAM6116 access controller: FSM states and strobe levels.
package sram_arb_ctrl_pkg;

   localparam logic STB_ON  = 1'b0;
   localparam logic STB_OFF = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      W_SETUP,
      W_STROBE,
      W_RECOVER,
      R_ARM,
      R_ACCESS,
      R_DONE,
      CLEAR
   } state_e;

   typedef struct packed {
      logic cs_b;
      logic we_b;
      logic oe_b;
   } strobe_t;

   // Strobe levels the SRAM sees while the FSM sits in a given state
   function automatic strobe_t strobe_of(input state_e s);
      strobe_t st;
      st = '{cs_b: STB_OFF, we_b: STB_OFF, oe_b: STB_OFF};
      case (s)
         W_SETUP:  st = '{cs_b: STB_ON,  we_b: STB_OFF, oe_b: STB_OFF};
         W_STROBE: st = '{cs_b: STB_ON,  we_b: STB_ON,  oe_b: STB_OFF};
         R_ARM:    st = '{cs_b: STB_OFF, we_b: STB_ON,  oe_b: STB_OFF};
         R_ACCESS: st = '{cs_b: STB_ON,  we_b: STB_ON,  oe_b: STB_ON};
         R_DONE:   st = '{cs_b: STB_OFF, we_b: STB_ON,  oe_b: STB_OFF};
         default:  st = '{cs_b: STB_OFF, we_b: STB_OFF, oe_b: STB_OFF};
      endcase
      return st;
   endfunction

endpackage

// File: rtl/sram_arb_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; rr_last remembers the most recent winner (1 = B).
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_b,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt_c
);

   logic rr_last;

   always_comb begin
      gnt_c = 2'b00;
      case (req)
         2'b01:   gnt_c = 2'b01;
         2'b10:   gnt_c = 2'b10;
         2'b11:   gnt_c = rr_last ? 2'b01 : 2'b10;
         default: gnt_c = 2'b00;
      endcase
   end

   // Reset to B so A wins the first tie
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         rr_last <= 1'b1;
      end else if (advance && (gnt_c != 2'b00)) begin
         rr_last <= gnt_c[1];
      end
   end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Round-robin access controller for a 16x4 async SRAM with registered strobe sequencing.
// Optional SRAM_CLEAR_EN: zero the whole array after every reset before serving requests.
module sram_arb_ctrl
   import sram_arb_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned DATA_W   = 4,
   parameter int unsigned WR_PULSE = 2,
   parameter int unsigned RD_WAIT  = 2
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              sram_cs_b,
   output logic              sram_we_b,
   output logic              sram_oe_b,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_din,
   input  logic [DATA_W-1:0] sram_dout
);

   localparam int unsigned MAX_PH = (WR_PULSE > RD_WAIT) ? WR_PULSE : RD_WAIT;
   localparam int unsigned CNT_W  = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_PULSE - 1);
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);

`ifdef SRAM_CLEAR_EN
   localparam state_e RST_STATE = CLEAR;
`else
   localparam state_e RST_STATE = IDLE;
`endif

   state_e            state, state_nxt;
   logic [CNT_W-1:0]  ph_cnt, ph_cnt_nxt;
   logic              own_b, own_b_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [DATA_W-1:0] din_nxt;
   logic              a_gnt_nxt, b_gnt_nxt;
   logic              rd_capture;
   logic              sel_we;
   logic              arb_adv;
   logic [1:0]        arb_gnt;

`ifdef SRAM_CLEAR_EN
   logic              clr_active, clr_active_nxt;
   logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;
`endif

   assign arb_adv = (state == IDLE);

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_b   (rst_b),
      .req     ({b_req, a_req}),
      .advance (arb_adv),
      .gnt_c   (arb_gnt)
   );

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state  <= RST_STATE;
         ph_cnt <= '0;
         own_b  <= 1'b0;
      end else begin
         state  <= state_nxt;
         ph_cnt <= ph_cnt_nxt;
         own_b  <= own_b_nxt;
      end
   end

   // Next state, capture values and pulse requests
   always_comb begin
      state_nxt  = state;
      ph_cnt_nxt = ph_cnt;
      own_b_nxt  = own_b;
      addr_nxt   = sram_addr;
      din_nxt    = sram_din;
      a_gnt_nxt  = 1'b0;
      b_gnt_nxt  = 1'b0;
      rd_capture = 1'b0;
      sel_we     = 1'b0;
`ifdef SRAM_CLEAR_EN
      clr_active_nxt = clr_active;
      clr_addr_nxt   = clr_addr;
`endif
      case (state)
         IDLE: begin
            if (arb_gnt != 2'b00) begin
               own_b_nxt = arb_gnt[1];
               a_gnt_nxt = arb_gnt[0];
               b_gnt_nxt = arb_gnt[1];
               addr_nxt  = arb_gnt[1] ? b_addr : a_addr;
               sel_we    = arb_gnt[1] ? b_we : a_we;
               if (sel_we) begin
                  din_nxt   = arb_gnt[1] ? b_wdata : a_wdata;
                  state_nxt = W_SETUP;
               end else begin
                  state_nxt = R_ARM;
               end
            end
         end
         W_SETUP: begin
            ph_cnt_nxt = '0;
            state_nxt  = W_STROBE;
         end
         W_STROBE: begin
            if (ph_cnt == WR_LAST) state_nxt = W_RECOVER;
            else                   ph_cnt_nxt = ph_cnt + CNT_W'(1);
         end
         W_RECOVER: begin
            state_nxt = IDLE;
`ifdef SRAM_CLEAR_EN
            if (clr_active) begin
               state_nxt = CLEAR;
               if (clr_addr == '1) clr_active_nxt = 1'b0;
               else                clr_addr_nxt   = clr_addr + ADDR_W'(1);
            end
`endif
         end
         R_ARM: begin
            ph_cnt_nxt = '0;
            state_nxt  = R_ACCESS;
         end
         R_ACCESS: begin
            if (ph_cnt == RD_LAST) begin
               rd_capture = 1'b1;
               state_nxt  = R_DONE;
            end else begin
               ph_cnt_nxt = ph_cnt + CNT_W'(1);
            end
         end
         R_DONE: state_nxt = IDLE;
         CLEAR: begin
            state_nxt = IDLE;
`ifdef SRAM_CLEAR_EN
            if (clr_active) begin
               addr_nxt  = clr_addr;
               din_nxt   = '0;
               state_nxt = W_SETUP;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   // SRAM-facing and requester-facing outputs, all straight from flops
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         {sram_cs_b, sram_we_b, sram_oe_b} <= {STB_OFF, STB_OFF, STB_OFF};
         sram_addr <= '0;
         sram_din  <= '0;
         rdata     <= '0;
         a_gnt     <= 1'b0;
         b_gnt     <= 1'b0;
         a_rvalid  <= 1'b0;
         b_rvalid  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         {sram_cs_b, sram_we_b, sram_oe_b} <= strobe_of(state_nxt);
         sram_addr <= addr_nxt;
         sram_din  <= din_nxt;
         if (rd_capture) rdata <= sram_dout;
         a_gnt     <= a_gnt_nxt;
         b_gnt     <= b_gnt_nxt;
         a_rvalid  <= rd_capture && !own_b;
         b_rvalid  <= rd_capture && own_b;
         busy      <= (state_nxt != IDLE);
      end
   end

`ifdef SRAM_CLEAR_EN
   // Clear sweep restarts from address 0 on every reset
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         clr_active <= 1'b1;
         clr_addr   <= '0;
      end else begin
         clr_active <= clr_active_nxt;
         clr_addr   <= clr_addr_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Randomized bench for sram_arb_ctrl with a behavioural SRAM6116 and a transaction-level reference model.
module tb_sram_arb_ctrl;

   localparam int unsigned ADDR_W   = 4;
   localparam int unsigned DATA_W   = 4;
   localparam int unsigned WR_PULSE = 2;
   localparam int unsigned RD_WAIT  = 2;
   localparam int unsigned DEPTH    = 16;
   localparam int unsigned LIMIT    = 2000;

   logic              clk = 1'b0;
   logic              rst_b;
   logic              a_req, a_we, b_req, b_we;
   logic [ADDR_W-1:0] a_addr, b_addr;
   logic [DATA_W-1:0] a_wdata, b_wdata;
   logic              a_gnt, a_rvalid, b_gnt, b_rvalid, busy;
   logic [DATA_W-1:0] rdata;
   logic              sram_cs_b, sram_we_b, sram_oe_b;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_din, sram_dout;

   logic [DATA_W-1:0] sram_mem [DEPTH];
   logic [DATA_W-1:0] ref_mem  [DEPTH];
   logic [DATA_W-1:0] junk;

   int n_cmp = 0;
   int n_bad = 0;
   int wlen  = 0;
   bit last_b;

   always #5 clk = ~clk;

   sram_arb_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_PULSE(WR_PULSE), .RD_WAIT(RD_WAIT)
   ) dut (
      .clk(clk), .rst_b(rst_b),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid),
      .rdata(rdata), .busy(busy),
      .sram_cs_b(sram_cs_b), .sram_we_b(sram_we_b), .sram_oe_b(sram_oe_b),
      .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
   );

   // Device model: latch on WE_b falling edge with CS_b low, drive only when all strobes low
   initial begin
      for (int i = 0; i < DEPTH; i++) sram_mem[i] = DATA_W'(i * 7 + 3);
      sram_mem[15] = 4'hA;
      forever begin
         @(negedge sram_we_b);
         if (!sram_cs_b) sram_mem[sram_addr] = sram_din;
      end
   end

   always @(posedge clk) junk <= DATA_W'($urandom);
   assign sram_dout = (!sram_cs_b && !sram_we_b && !sram_oe_b) ? sram_mem[sram_addr] : junk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Strobe-level monitor: write pulse width and OE only during a real read access
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_b) begin
            wlen = 0;
         end else begin
            if (!sram_cs_b && !sram_we_b && sram_oe_b) begin
               wlen++;
            end else if (wlen != 0) begin
               check("we_pulse_len", 32'(wlen), 32'(WR_PULSE));
               wlen = 0;
            end
            if (!sram_oe_b) check("oe_needs_cs_we", 32'({sram_cs_b, sram_we_b}), 32'd0);
         end
      end
   end

   task automatic wait_idle(output int cnt);
      cnt = 0;
      do begin
         check("gnt_while_busy", 32'({a_gnt, b_gnt}), 32'd0);
         tick();
         cnt++;
      end while (busy && cnt < LIMIT);
      check("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic reset_model();
      last_b = 1'b1;
`ifdef SRAM_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
   endtask

   task automatic check_after_clear();
      int cnt;
      wait_idle(cnt);
`ifdef SRAM_CLEAR_EN
      check("clear_busy_len", 32'(cnt >= int'(DEPTH * (2 + WR_PULSE))), 32'd1);
`endif
   endtask

   // One granted access: grant next cycle, then watch every cycle until IDLE
   task automatic serve(input bit who_b, input bit ghost);
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data, exp_rd;
      int                len;
      bit                rv;
      tick();
      check("a_gnt", 32'(a_gnt), 32'(!who_b));
      check("b_gnt", 32'(b_gnt), 32'(who_b));
      last_b = who_b;
      we   = who_b ? b_we : a_we;
      addr = who_b ? b_addr : a_addr;
      data = who_b ? b_wdata : a_wdata;
      if (who_b) b_req = 1'b0; else a_req = 1'b0;
      len    = we ? int'(2 + WR_PULSE) : int'(2 + RD_WAIT);
      exp_rd = ref_mem[addr];
      if (we) ref_mem[addr] = data;
      for (int k = 1; k <= len; k++) begin
         tick();
         if (k == 1) begin
            check("sram_addr", 32'(sram_addr), 32'(addr));
            if (we) check("sram_din", 32'(sram_din), 32'(data));
         end
         rv = !we && (k == int'(RD_WAIT + 1));
         check("a_rvalid", 32'(a_rvalid), 32'(rv && !who_b));
         check("b_rvalid", 32'(b_rvalid), 32'(rv && who_b));
         if (rv) check("rdata", 32'(rdata), 32'(exp_rd));
         check("gnt_quiet", 32'({a_gnt, b_gnt}), 32'd0);
         check("busy", 32'(busy), 32'(k < len));
         // A request raised and withdrawn mid-access must never be granted
         if (ghost && k == 1) begin
            if (who_b) begin
               a_req = 1'b1; a_we = 1'($urandom); a_addr = ADDR_W'($urandom); a_wdata = DATA_W'($urandom);
            end else begin
               b_req = 1'b1; b_we = 1'($urandom); b_addr = ADDR_W'($urandom); b_wdata = DATA_W'($urandom);
            end
         end
         if (ghost && k == 2) begin
            if (who_b) a_req = 1'b0; else b_req = 1'b0;
         end
      end
   endtask

   // mode 0: A only, 1: B only, 2: both in the same cycle
   task automatic do_round(input int mode,
                           input logic aw, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                           input logic bw, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd,
                           input bit ghost);
      bit first_b;
      if (mode == 0)      first_b = 1'b0;
      else if (mode == 1) first_b = 1'b1;
      else                first_b = !last_b;
      a_we = aw; a_addr = aa; a_wdata = ad; a_req = (mode != 1);
      b_we = bw; b_addr = ba; b_wdata = bd; b_req = (mode != 0);
      serve(first_b, ghost && mode != 2);
      if (mode == 2) serve(!first_b, 1'b0);
   endtask

   // Reset asserted during the first strobe cycle of a write
   task automatic abort_write(input logic [ADDR_W-1:0] addr);
      a_req = 1'b1; a_we = 1'b1; a_addr = addr; a_wdata = ref_mem[addr];
      tick();
      check("abort_gnt", 32'(a_gnt), 32'd1);
      a_req = 1'b0;
      tick();
      check("abort_in_strobe", 32'({sram_cs_b, sram_we_b}), 32'd0);
      rst_b = 1'b0;
      #1;
      for (int r = 0; r < 2; r++) begin
         check("abort_strobes", 32'({sram_cs_b, sram_we_b, sram_oe_b}), 32'h7);
         check("abort_busy", 32'(busy), 32'd0);
         check("abort_pulses", 32'({a_gnt, b_gnt, a_rvalid, b_rvalid}), 32'd0);
         tick();
      end
      rst_b = 1'b1;
      reset_model();
      check_after_clear();
   endtask

   initial begin
      rst_b = 1'b0;
      a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = DATA_W'(i * 7 + 3);
      ref_mem[15] = 4'hA;
      repeat (3) tick();
      check("rst_strobes", 32'({sram_cs_b, sram_we_b, sram_oe_b}), 32'h7);
      check("rst_addr", 32'(sram_addr), 32'd0);
      check("rst_din", 32'(sram_din), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pulses", 32'({a_gnt, b_gnt, a_rvalid, b_rvalid}), 32'd0);
      rst_b = 1'b1;
      reset_model();
      check_after_clear();

      do_round(0, 1'b1, 4'd3, 4'h9, 1'b0, 4'd0, 4'h0, 1'b0);
      do_round(1, 1'b0, 4'd0, 4'h0, 1'b0, 4'd3, 4'h0, 1'b0);
      do_round(1, 1'b0, 4'd0, 4'h0, 1'b0, 4'd15, 4'h0, 1'b0);
      do_round(2, 1'b0, 4'd5, 4'h0, 1'b0, 4'd6, 4'h0, 1'b0);
      do_round(2, 1'b0, 4'd3, 4'h0, 1'b0, 4'd15, 4'h0, 1'b0);
      do_round(2, 1'b1, 4'd0, 4'hC, 1'b0, 4'd0, 4'h5, 1'b0);
      do_round(0, 1'b0, 4'd0, 4'h0, 1'b0, 4'd0, 4'h0, 1'b1);
      abort_write(4'd7);
      do_round(1, 1'b0, 4'd0, 4'h0, 1'b1, 4'd7, 4'h6, 1'b0);
      do_round(0, 1'b0, 4'd7, 4'h0, 1'b0, 4'd0, 4'h0, 1'b0);

      for (int n = 0; n < 80; n++) begin
         do_round(int'($urandom_range(0, 2)),
                  1'($urandom), ADDR_W'($urandom), DATA_W'($urandom),
                  1'($urandom), ADDR_W'($urandom), DATA_W'($urandom),
                  1'($urandom));
      end

      for (int i = 0; i < DEPTH; i++) check("mem_contents", 32'(sram_mem[i]), 32'(ref_mem[i]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
